// File: rtl/m_sb_pkg.sv
// rtl/m_sb_pkg.sv - shared types, depth default and byte-merge helper for the store buffer
package m_sb_pkg;

    localparam int SB_DEPTH = 4;

    typedef struct packed {
        logic [29:0] word_addr;
        logic [31:0] data;
        logic [3:0]  be;
    } sb_entry_t;

    typedef enum logic {
        SB_IDLE = 1'b0,
        SB_REQ  = 1'b1
    } sb_state_t;

    // Per-lane select: enabled lanes take the new byte, the rest keep the old one.
    function automatic logic [31:0] sb_merge_data(input logic [31:0] old_data,
                                                  input logic [31:0] new_data,
                                                  input logic [3:0]  be);
        logic [31:0] res;
        for (int l = 0; l < 4; l++) begin
            res[8*l +: 8] = be[l] ? new_data[8*l +: 8] : old_data[8*l +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/m_sb_fifo.sv
// rtl/m_sb_fifo.sv - entry storage with push/merge/pop and load address match
//
// Ports:
//   in_valid/in_entry/in_ready  store offered by the formatter (word address, data, lanes)
//   pop                         drop the head entry this edge
//   ld_word/ld_hit              word address of a load, hit on any occupied entry
//   head_entry                  current head (the write in flight)
//   next_head_entry             value the head will hold after a pop on this edge
//   count/count_next            occupancy now and after this edge
module m_sb_fifo
    import m_sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    input  sb_entry_t     in_entry,
    output logic          in_ready,
    input  logic          pop,
    input  logic [29:0]   ld_word,
    output logic          ld_hit,
    output sb_entry_t     head_entry,
    output sb_entry_t     next_head_entry,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_next
);

    sb_entry_t     mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] youngest;
    logic [AW-1:0] head_p1;
    logic          merge_possible;
    logic          accept;
    logic          do_merge;
    logic          do_push;
    sb_entry_t     merged_entry;

    assign youngest = tail - 1'b1;
    assign head_p1  = head + 1'b1;

    // The youngest entry is never the head once two or more are queued, so the
    // in-flight write can never be modified underneath the bus.
    assign merge_possible = (count >= CW'(2)) && (mem[youngest].word_addr == in_entry.word_addr);
    assign in_ready       = (count < CW'(DEPTH)) || merge_possible;
    assign accept         = in_valid && in_ready && (|in_entry.be);
    assign do_merge       = accept && merge_possible;
    assign do_push        = accept && !merge_possible;
    assign count_next     = count + CW'(do_push) - CW'(pop);

    always_comb begin
        merged_entry           = mem[youngest];
        merged_entry.data      = sb_merge_data(mem[youngest].data, in_entry.data, in_entry.be);
        merged_entry.be        = mem[youngest].be | in_entry.be;
    end

    assign head_entry = mem[head];

    // With a single entry the successor is whatever is being pushed on this
    // edge; with two, the successor may be the entry being merged right now.
    always_comb begin
        next_head_entry = mem[head_p1];
        if (count == CW'(1)) begin
            next_head_entry = in_entry;
        end else if (do_merge && (youngest == head_p1)) begin
            next_head_entry = merged_entry;
        end
    end

    always_comb begin
        logic [AW-1:0] off;
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - head;
            if (({1'b0, off} < count) && (mem[i].word_addr == ld_word)) begin
                ld_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop) begin
                head <= head_p1;
            end
            if (do_push) begin
                tail <= tail + 1'b1;
            end
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail] <= in_entry;
        end
        if (do_merge) begin
            mem[youngest] <= merged_entry;
        end
    end

endmodule

// File: rtl/m_store_buffer.sv
// rtl/m_store_buffer.sv - posted-write store buffer with word merge and in-order req/ack drain
//
// Ports:
//   in_valid/in_addr/in_data/in_byte_en/in_ready  formatted store from the M stage
//   ld_valid/ld_addr/ld_stall                     load hazard check against pending words
//   bus_req/bus_addr/bus_wdata/bus_byte_en/bus_ack write port to data memory
//   sb_count/sb_empty                             occupancy status
module m_store_buffer
    import m_sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic [31:0]              in_addr,
    input  logic [31:0]              in_data,
    input  logic [3:0]               in_byte_en,
    output logic                     in_ready,
    input  logic                     ld_valid,
    input  logic [31:0]              ld_addr,
    output logic                     ld_stall,
    output logic                     bus_req,
    output logic [31:0]              bus_addr,
    output logic [31:0]              bus_wdata,
    output logic [3:0]               bus_byte_en,
    input  logic                     bus_ack,
    output logic [$clog2(DEPTH):0]   sb_count,
    output logic                     sb_empty
);

    localparam int CW = $clog2(DEPTH) + 1;

    sb_state_t     state_q;
    sb_state_t     state_d;
    sb_entry_t     bus_q;
    sb_entry_t     load_entry;
    logic          load;
    logic          pop;
    logic          ld_hit;
    sb_entry_t     in_entry;
    sb_entry_t     head_entry;
    sb_entry_t     next_head_entry;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{in_addr[1:0], ld_addr[1:0]};

    assign in_entry.word_addr = in_addr[31:2];
    assign in_entry.data      = in_data;
    assign in_entry.be        = in_byte_en;

    m_sb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk             (clk),
        .reset_n         (reset_n),
        .in_valid        (in_valid),
        .in_entry        (in_entry),
        .in_ready        (in_ready),
        .pop             (pop),
        .ld_word         (ld_addr[31:2]),
        .ld_hit          (ld_hit),
        .head_entry      (head_entry),
        .next_head_entry (next_head_entry),
        .count           (count),
        .count_next      (count_next)
    );

    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        load_entry = head_entry;
        pop        = 1'b0;
        case (state_q)
            SB_IDLE: begin
                if (count != '0) begin
                    load    = 1'b1;
                    state_d = SB_REQ;
                end
            end
            SB_REQ: begin
                if (bus_ack) begin
                    pop = 1'b1;
                    if (count_next != '0) begin
                        // Back-to-back issue: successor goes out on the same edge.
                        load       = 1'b1;
                        load_entry = next_head_entry;
                    end else begin
                        state_d = SB_IDLE;
                    end
                end
            end
            default: state_d = SB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SB_IDLE;
            bus_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                bus_q <= load_entry;
            end
        end
    end

    assign bus_req     = (state_q == SB_REQ);
    assign bus_addr    = {bus_q.word_addr, 2'b00};
    assign bus_wdata   = bus_q.data;
    assign bus_byte_en = bus_q.be;
    assign ld_stall    = ld_valid && ld_hit;
    assign sb_count    = count;
    assign sb_empty    = (count == '0);

endmodule

// File: tb/tb_m_store_buffer.sv
// tb/tb_m_store_buffer.sv - self-checking bench for m_store_buffer
module tb_m_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [3:0]  in_byte_en;
    logic        in_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_stall;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_byte_en;
    logic        bus_ack;
    logic [2:0]  sb_count;
    logic        sb_empty;

    m_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_addr     (in_addr),
        .in_data     (in_data),
        .in_byte_en  (in_byte_en),
        .in_ready    (in_ready),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_stall    (ld_stall),
        .bus_req     (bus_req),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_byte_en (bus_byte_en),
        .bus_ack     (bus_ack),
        .sb_count    (sb_count),
        .sb_empty    (sb_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] w;
        logic [31:0] d;
        logic [3:0]  be;
    } ment_t;

    // Reference: an ordered list of pending words, plus the write the bus is presenting.
    ment_t q[$];
    ment_t m_bus;
    logic  m_req;

    int n_tests = 0;
    int n_fail  = 0;

    logic        obs_rdy;
    logic        obs_stall;
    logic        obs_req;
    logic [31:0] obs_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_req = 1'b0;
        m_bus = '{w: '0, d: '0, be: '0};
    endtask

    // One clock: drive, compare against the reference, advance the reference, take the edge.
    task automatic tick(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic ack, input logic lv,
                        input logic [31:0] la);
        int    sz;
        logic  merge_ok;
        logic  rdy;
        logic  acc;
        logic  popd;
        logic  stall;
        logic  req_was;
        ment_t e;
        in_valid = v; in_addr = a; in_data = d; in_byte_en = be;
        bus_ack = ack; ld_valid = lv; ld_addr = la;
        #1;
        obs_rdy = in_ready; obs_stall = ld_stall; obs_req = bus_req; obs_addr = bus_addr;
        sz       = q.size();
        merge_ok = (sz >= 2) && (q[sz-1].w == a[31:2]);
        rdy      = (sz < DEPTH) || merge_ok;
        stall    = 1'b0;
        foreach (q[k]) if (q[k].w == la[31:2]) stall = lv;
        chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
        chk("ld_stall", {31'b0, ld_stall}, {31'b0, stall});
        chk("bus_req", {31'b0, bus_req}, {31'b0, m_req});
        if (m_req) begin
            chk("bus_addr", bus_addr, {m_bus.w, 2'b00});
            chk("bus_wdata", bus_wdata, m_bus.d);
            chk("bus_byte_en", {28'b0, bus_byte_en}, {28'b0, m_bus.be});
        end
        chk("sb_count", {29'b0, sb_count}, sz);
        chk("sb_empty", {31'b0, sb_empty}, {31'b0, (sz == 0)});
        acc     = v && rdy && (|be);
        popd    = m_req && ack;
        req_was = m_req;
        if (acc && merge_ok) begin
            for (int l = 0; l < 4; l++) if (be[l]) q[sz-1].d[8*l +: 8] = d[8*l +: 8];
            q[sz-1].be = q[sz-1].be | be;
        end
        if (popd) void'(q.pop_front());
        if (acc && !merge_ok) begin
            e.w = a[31:2]; e.d = d; e.be = be;
            q.push_back(e);
        end
        if (req_was) begin
            if (popd) begin
                if (q.size() > 0) m_bus = q[0];
                else m_req = 1'b0;
            end
        end else if (sz > 0) begin
            m_req = 1'b1;
            m_bus = q[0];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ack);
        tick(1'b0, 32'h0, 32'h0, 4'h0, ack, 1'b0, 32'h0);
    endtask

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic        ack;
        logic        lv;
        logic [31:0] la;
        logic        e_rdy;
        logic        e_stall;
        int          e_cnt;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic [3:0]  e_be;
    } vec_t;

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{1, 32'h200, 32'h000000EE, 4'b0001, 0, 0, 32'h0,   1, 0, 1, 0, 32'h0,   32'h0,        4'b0000};
        tbl[1]  = '{1, 32'h204, 32'h000000CD, 4'b0001, 0, 1, 32'h202, 1, 1, 2, 1, 32'h200, 32'h000000EE, 4'b0001};
        tbl[2]  = '{1, 32'h205, 32'h0000AB00, 4'b0010, 0, 1, 32'h204, 1, 1, 2, 1, 32'h200, 32'h000000EE, 4'b0001};
        tbl[3]  = '{1, 32'h300, 32'h33333333, 4'b1111, 0, 1, 32'h302, 1, 0, 3, 1, 32'h200, 32'h000000EE, 4'b0001};
        tbl[4]  = '{1, 32'h400, 32'h44444444, 4'b1111, 0, 1, 32'h302, 1, 1, 4, 1, 32'h200, 32'h000000EE, 4'b0001};
        tbl[5]  = '{1, 32'h500, 32'h55000055, 4'b1111, 0, 1, 32'h304, 0, 0, 4, 1, 32'h200, 32'h000000EE, 4'b0001};
        tbl[6]  = '{1, 32'h402, 32'h00770000, 4'b0100, 0, 0, 32'h0,   1, 0, 4, 1, 32'h200, 32'h000000EE, 4'b0001};
        tbl[7]  = '{1, 32'h400, 32'hFFFFFFFF, 4'b0000, 0, 0, 32'h0,   1, 0, 4, 1, 32'h200, 32'h000000EE, 4'b0001};
        tbl[8]  = '{0, 32'h0,   32'h0,        4'b0000, 1, 1, 32'h200, 0, 1, 3, 1, 32'h204, 32'h0000ABCD, 4'b0011};
        tbl[9]  = '{0, 32'h0,   32'h0,        4'b0000, 1, 1, 32'h200, 1, 0, 2, 1, 32'h300, 32'h33333333, 4'b1111};
        tbl[10] = '{1, 32'h404, 32'h55555555, 4'b1111, 1, 0, 32'h0,   1, 0, 2, 1, 32'h400, 32'h44774444, 4'b1111};
        tbl[11] = '{0, 32'h0,   32'h0,        4'b0000, 1, 1, 32'h302, 1, 0, 1, 1, 32'h404, 32'h55555555, 4'b1111};
        tbl[12] = '{0, 32'h0,   32'h0,        4'b0000, 1, 0, 32'h0,   1, 0, 0, 0, 32'h0,   32'h0,        4'b0000};
        tbl[13] = '{0, 32'h0,   32'h0,        4'b0000, 0, 0, 32'h0,   1, 0, 0, 0, 32'h0,   32'h0,        4'b0000};

        reset_n = 1'b0; in_valid = 0; in_addr = 0; in_data = 0; in_byte_en = 0;
        ld_valid = 0; ld_addr = 0; bus_ack = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst bus_req", {31'b0, bus_req}, 32'd0);
        chk("rst bus_addr", bus_addr, 32'd0);
        chk("rst bus_wdata", bus_wdata, 32'd0);
        chk("rst bus_byte_en", {28'b0, bus_byte_en}, 32'd0);
        chk("rst in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst ld_stall", {31'b0, ld_stall}, 32'd0);
        chk("rst sb_empty", {31'b0, sb_empty}, 32'd1);
        chk("rst sb_count", {29'b0, sb_count}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single word store with ack tied high.
        tick(1'b1, 32'h100, 32'h11223344, 4'b1111, 1'b1, 1'b0, 32'h0);
        chk("sw req after edge1", {31'b0, bus_req}, 32'd0);
        idle(1'b1);
        chk("sw req after edge2", {31'b0, bus_req}, 32'd1);
        chk("sw bus_addr", bus_addr, 32'h100);
        chk("sw bus_wdata", bus_wdata, 32'h11223344);
        chk("sw bus_byte_en", {28'b0, bus_byte_en}, 32'hF);
        idle(1'b1);
        chk("sw empty after ack", {31'b0, sb_empty}, 32'd1);
        idle(1'b0);

        // Merge, full, zero-enable, load hazard and push+pop table.
        for (int i = 0; i < 14; i++) begin
            tick(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].be, tbl[i].ack, tbl[i].lv, tbl[i].la);
            chk($sformatf("tbl%0d in_ready", i), {31'b0, obs_rdy}, {31'b0, tbl[i].e_rdy});
            chk($sformatf("tbl%0d ld_stall", i), {31'b0, obs_stall}, {31'b0, tbl[i].e_stall});
            chk($sformatf("tbl%0d sb_count", i), {29'b0, sb_count}, tbl[i].e_cnt);
            chk($sformatf("tbl%0d bus_req", i), {31'b0, bus_req}, {31'b0, tbl[i].e_req});
            if (tbl[i].e_req) begin
                chk($sformatf("tbl%0d bus_addr", i), bus_addr, tbl[i].e_addr);
                chk($sformatf("tbl%0d bus_wdata", i), bus_wdata, tbl[i].e_data);
                chk($sformatf("tbl%0d bus_be", i), {28'b0, bus_byte_en}, {28'b0, tbl[i].e_be});
            end
        end

        // Back-to-back drain: three consecutive req cycles, in order.
        tick(1'b1, 32'h800, 32'hA0A0A0A0, 4'b1111, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 32'h804, 32'hA1A1A1A1, 4'b1111, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 32'h808, 32'hA2A2A2A2, 4'b1111, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            idle(1'b1);
            chk($sformatf("b2b%0d req", k), {31'b0, obs_req}, 32'd1);
            chk($sformatf("b2b%0d addr", k), obs_addr, 32'h800 + 32'(4 * k));
        end
        chk("b2b done req", {31'b0, bus_req}, 32'd0);
        chk("b2b done empty", {31'b0, sb_empty}, 32'd1);

        // Reset in the middle of a request with three entries queued.
        tick(1'b1, 32'h900, 32'h1, 4'b1111, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 32'h904, 32'h2, 4'b1111, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 32'h908, 32'h3, 4'b1111, 1'b0, 1'b0, 32'h0);
        chk("mid req before rst", {31'b0, bus_req}, 32'd1);
        chk("mid count before rst", {29'b0, sb_count}, 32'd3);
        in_valid = 1'b0; bus_ack = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst async bus_req", {31'b0, bus_req}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst release count", {29'b0, sb_count}, 32'd0);
        chk("rst release empty", {31'b0, sb_empty}, 32'd1);

        // Random traffic on a small address window so merges and hazards are frequent.
        for (int n = 0; n < 600; n++) begin
            tick(1'($urandom_range(0, 3) != 0),
                 32'h100 + 32'($urandom_range(0, 23)),
                 $urandom,
                 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 1)),
                 32'h100 + 32'($urandom_range(0, 27)));
        end
        for (int n = 0; n < 10; n++) idle(1'b1);
        chk("final empty", {31'b0, sb_empty}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/m_store_buffer.md
# m_store_buffer

Posted-write store buffer between the M-stage store formatter and the data-memory bus. It accepts formatted stores (word address, positioned data, byte enables) in one cycle and queues them. It merges a store into the youngest queued entry when both target the same word, and drains entries in order over a req/ack bus. Loads that hit a pending word get a stall so the pipeline never reads stale memory.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  store offered this cycle
- in_addr  in  32  store byte address; only [31:2] is stored
- in_data  in  32  data already shifted into byte lanes
- in_byte_en  in  4  lane enables; 4'b0000 means no store
- in_ready  out  1  buffer can accept the offered store
- ld_valid  in  1  M-stage load present
- ld_addr  in  32  load byte address
- ld_stall  out  1  load must wait; a pending store targets the same word
- bus_req  out  1  write request to data memory
- bus_addr  out  32  word-aligned address, {entry_addr, 2'b00}
- bus_wdata  out  32  write data
- bus_byte_en  out  4  write lane enables
- bus_ack  in  1  memory accepted the current request
- sb_count  out  $clog2(DEPTH)+1  occupied entries
- sb_empty  out  1  sb_count == 0

## Operation
- Accept: a store is accepted when `in_valid && in_ready && |in_byte_en`. A store with zero enables is ignored and still sees in_ready.
- Merge: the store merges if the youngest entry's word address equals in_addr[31:2] and that entry is not the head (count ≥ 2). Each enabled lane overwrites that entry's data byte, and the entry's enables become the OR of old and new. count is unchanged.
- Otherwise the store is written at the tail and count increments.
- in_ready = (count < DEPTH) || merge_possible. in_ready depends only on registered state and the in_* inputs, never on bus_ack.
- FSM IDLE:
  - If count > 0, load the bus_* registers from the head and go to REQ.
- FSM REQ:
  - bus_req = 1 and bus_* are held stable until bus_ack.
  - On bus_ack, pop the head.
  - If entries remain after the pop, load the next head into bus_* in the same edge and stay in REQ (back-to-back issue). Otherwise go to IDLE.
- Head is frozen: the head entry never merges, in IDLE or REQ. The merge condition excludes it structurally.
- ld_stall = ld_valid && (some occupied entry, including the in-flight head, has word address == ld_addr[31:2]). A store being accepted in the same cycle is not compared.
- Pointers are modulo DEPTH and wrap naturally.
- Simultaneous push and pop:
  - When not full: count is unchanged, and the tail and head advance together.
  - When full: in_ready = 0 that cycle, unless the store merges.
  - A merge together with a pop at count == 2: the merge targets the youngest entry, which becomes the head after the pop. This is legal because the pop and the merge apply on the same edge, and the bus registers are loaded from the merged value.

## Timing
- Reset (async assert, sync-released behaviour is the integrator's job) drops all entries:
  - count = 0, head = tail = 0, state = IDLE
  - bus_req = 0, bus_addr = 0, bus_wdata = 0, bus_byte_en = 0
  - in_ready = 1, ld_stall = 0 while ld_valid = 0, sb_empty = 1
- Reset during REQ abandons the in-flight write. The bus side must tolerate req dropping.
- Latency:
  - A store accepted at edge N into an empty buffer gives bus_req = 1 after edge N+1.
  - The entry is popped at the edge where bus_ack = 1.
  - Sustained throughput is one store per cycle when bus_ack is held high.
- sb_count and sb_empty are registered, and they reflect the edge that just occurred.
- ld_stall is combinational from ld_* and registered entries.

## Structure
- Package `m_sb_pkg`:
  - DEPTH default
  - entry struct {word_addr[29:0], data[31:0], be[3:0]}
  - FSM enum {SB_IDLE, SB_REQ}
  - merge helper function (per-lane byte select)
- One sub-module, `m_sb_fifo`:
  - entry storage, head/tail/count, push/merge/pop
  - combinational match vector for ld_stall
- The top level holds the bus FSM and the bus_* registers.

## Test plan
- Reset, then sw 0x11223344 to 0x100 (be 1111) with bus_ack tied 1 → bus_req rises after edge 2. bus_addr = 0x100, bus_wdata = 0x11223344, bus_byte_en = 1111. sb_empty = 1 after the ack edge.
- bus_ack = 0. Push sb to 0x200 (be 0001), then sb to 0x204, 0x201 (be 0010, data 0x0000AB00) → the third store merges into the 0x204 entry? No. Use 0x204 byte then 0x205 byte → the merged entry has be 0011, count = 2, and the head (0x200) is unchanged.
- Fill 4 distinct words with bus_ack = 0 → in_ready = 0. A fifth store to a new word is held. A fifth store to the youngest entry's word merges and is accepted.
- Pending store at 0x300; ld_valid with ld_addr 0x302 → ld_stall = 1. With ld_addr 0x304 → ld_stall = 0. After the ack of 0x300 → ld_stall = 0.
- Push 3 stores, then hold bus_ack = 1 → three consecutive req cycles with in-order addresses and no IDLE bubble.
- Assert reset_n = 0 mid-REQ with 3 entries → bus_req = 0 immediately, and sb_count = 0 and sb_empty = 1 after release.
